// File: rtl/conv_column_stream.sv
// conv_column_stream: streaming 3x3 same-size convolution, one column per beat.
// Zero padding on all borders; output wraps modulo 2^OUT_NB.
// Optional macro CONV_RELU_EN: negative output pixels are forced to 0.
// Ports:
//   clock, i_reset            rising-edge clock, sync active-high reset
//   i_kernel_load, i_kernel   latch 3x3 kernel (IDLE only), k[0][0] at MSB
//   i_col_valid/o_col_ready   input column handshake, row 0 at MSB
//   o_out_valid/i_out_ready   output column handshake
//   o_out_col, o_last         output column, last-column-of-frame flag
//   o_busy                    high whenever a frame is in progress
module conv_column_stream #(
  parameter int IMG_HEIGHT = 8,
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_NB     = 8,
  parameter int KERNEL_NB  = 8,
  parameter int OUT_NB     = IMG_NB + KERNEL_NB + 4
) (
  input  logic                         clock,
  input  logic                         i_reset,
  input  logic                         i_kernel_load,
  input  logic [9*KERNEL_NB-1:0]       i_kernel,
  input  logic                         i_col_valid,
  output logic                         o_col_ready,
  input  logic [IMG_HEIGHT*IMG_NB-1:0] i_col,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [IMG_HEIGHT*OUT_NB-1:0] o_out_col,
  output logic                         o_last,
  output logic                         o_busy
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int CN = IMG_HEIGHT * IMG_NB;
  localparam int ON = IMG_HEIGHT * OUT_NB;
  localparam int PW = IMG_NB + KERNEL_NB;
  localparam logic [CW-1:0] LAST = CW'(IMG_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [CN-1:0]          col_m;
  logic [CN-1:0]          col_r;
  logic [9*KERNEL_NB-1:0] kern;

  logic          out_free;
  logic          accept;
  logic [CN-1:0] nxt_col;
  logic [ON-1:0] conv_col;

  assign out_free    = !o_out_valid || i_out_ready;
  assign o_col_ready = (state != FLUSH) && out_free;
  assign accept      = i_col_valid && o_col_ready;
  assign nxt_col     = (state == FLUSH) ? '0 : i_col;
  assign o_busy      = (state != IDLE);

  // The output is computed from the window as it will be after the
  // shift: left = M, middle = R, right = incoming column (0 in FLUSH).
  // Because the left column is always the pre-shift M, the L stage of
  // the window never needs its own storage.
  always_comb begin : conv_blk
    logic signed [OUT_NB-1:0]    acc;
    logic signed [PW-1:0]        prod;
    logic signed [KERNEL_NB-1:0] kc;
    logic signed [IMG_NB-1:0]    px;
    int                          rr;
    conv_col = '0;
    acc      = '0;
    prod     = '0;
    kc       = '0;
    px       = '0;
    rr       = 0;
    for (int r = 0; r < IMG_HEIGHT; r++) begin
      acc = '0;
      for (int i = 0; i < 3; i++) begin
        rr = r + i - 1;
        if (rr >= 0 && rr < IMG_HEIGHT) begin
          for (int j = 0; j < 3; j++) begin
            kc = kern[(8 - (i*3 + j))*KERNEL_NB +: KERNEL_NB];
            if (j == 0)
              px = col_m[(IMG_HEIGHT-1-rr)*IMG_NB +: IMG_NB];
            else if (j == 1)
              px = col_r[(IMG_HEIGHT-1-rr)*IMG_NB +: IMG_NB];
            else
              px = nxt_col[(IMG_HEIGHT-1-rr)*IMG_NB +: IMG_NB];
            prod = PW'(kc) * PW'(px);
            acc  = acc + OUT_NB'(prod);
          end
        end
      end
`ifdef CONV_RELU_EN
      if (acc[OUT_NB-1])
        acc = '0;
`else
`endif
      conv_col[(IMG_HEIGHT-1-r)*OUT_NB +: OUT_NB] = acc;
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      col_m       <= '0;
      col_r       <= '0;
      kern        <= '0;
      o_out_valid <= 1'b0;
      o_last      <= 1'b0;
      o_out_col   <= '0;
    end else begin
      if (i_out_ready) begin
        o_out_valid <= 1'b0;
        o_last      <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          col_m <= '0;
          if (i_kernel_load)
            kern <= i_kernel;
          if (accept) begin
            col_r <= i_col;
            cnt   <= CW'(1);
            state <= FILL;
          end
        end
        FILL, RUN: begin
          if (accept) begin
            col_m       <= col_r;
            col_r       <= i_col;
            o_out_col   <= conv_col;
            o_out_valid <= 1'b1;
            o_last      <= 1'b0;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= FLUSH;
            end else begin
              cnt   <= cnt + CW'(1);
              state <= RUN;
            end
          end
        end
        FLUSH: begin
          if (out_free) begin
            col_m       <= col_r;
            col_r       <= '0;
            o_out_col   <= conv_col;
            o_out_valid <= 1'b1;
            o_last      <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_column_stream.sv
// tb_conv_column_stream: scoreboard bench for conv_column_stream.
// Small frames, reference convolution model, backpressure and reset cases.
module tb_conv_column_stream;

  localparam int H   = 4;
  localparam int W   = 3;
  localparam int NB  = 8;
  localparam int KN  = 8;
  localparam int ONB = NB + KN + 4;
  localparam int CN  = H * NB;
  localparam int ON  = H * ONB;

  logic          clock = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_kernel_load = 1'b0;
  logic [9*KN-1:0] i_kernel = '0;
  logic          i_col_valid = 1'b0;
  logic          o_col_ready;
  logic [CN-1:0] i_col = '0;
  logic          o_out_valid;
  logic          i_out_ready = 1'b1;
  logic [ON-1:0] o_out_col;
  logic          o_last;
  logic          o_busy;

  conv_column_stream #(
    .IMG_HEIGHT(H),
    .IMG_WIDTH (W),
    .IMG_NB    (NB),
    .KERNEL_NB (KN)
  ) dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_kernel_load(i_kernel_load),
    .i_kernel     (i_kernel),
    .i_col_valid  (i_col_valid),
    .o_col_ready  (o_col_ready),
    .i_col        (i_col),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_out_col    (o_out_col),
    .o_last       (o_last),
    .o_busy       (o_busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [ON-1:0] col;
    logic          last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   kset[9];
  int   kmod[9];
  int   fr[W][H];
  logic rnd_done = 1'b0;

  task automatic check(input string tag,
                       input logic [ON-1:0] got,
                       input logic [ON-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: direct 3x3 convolution over the frame with zero padding.
  task automatic push_frame();
    exp_t e;
    int   acc;
    int   rr;
    int   cc;
    logic [ONB-1:0] v;
    for (int c = 0; c < W; c++) begin
      e.col  = '0;
      e.last = (c == W - 1);
      for (int r = 0; r < H; r++) begin
        acc = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            rr = r + i - 1;
            cc = c + j - 1;
            if (rr >= 0 && rr < H && cc >= 0 && cc < W)
              acc += kmod[i*3 + j] * fr[cc][rr];
          end
`ifdef CONV_RELU_EN
        if (acc < 0)
          acc = 0;
`else
`endif
        v = ONB'(acc);
        e.col[(H-1-r)*ONB +: ONB] = v;
      end
      sb.push_back(e);
    end
  endtask

  task automatic send_col(input int c);
    logic [CN-1:0] col;
    int n;
    col = '0;
    for (int r = 0; r < H; r++)
      col[(H-1-r)*NB +: NB] = NB'(fr[c][r]);
    i_col       = col;
    i_col_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!o_col_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("col_rdy", ON'(o_col_ready), ON'(1));
    @(posedge clock);
    #1;
    i_col_valid = 1'b0;
  endtask

  task automatic send_frame();
    for (int c = 0; c < W; c++)
      send_col(c);
  endtask

  task automatic load_kernel(input logic upd);
    logic [9*KN-1:0] k;
    k = '0;
    for (int i = 0; i < 9; i++)
      k[(8-i)*KN +: KN] = KN'(kset[i]);
    i_kernel      = k;
    i_kernel_load = 1'b1;
    @(posedge clock);
    #1;
    i_kernel_load = 1'b0;
    if (upd)
      for (int i = 0; i < 9; i++)
        kmod[i] = kset[i];
  endtask

  task automatic set_kernel(input int center, input int rest);
    for (int i = 0; i < 9; i++)
      kset[i] = (i == 4) ? center : rest;
  endtask

  task automatic fill_seq(input int base);
    for (int c = 0; c < W; c++)
      for (int r = 0; r < H; r++)
        fr[c][r] = base + c*H + r;
  endtask

  task automatic fill_const(input int v);
    for (int c = 0; c < W; c++)
      for (int r = 0; r < H; r++)
        fr[c][r] = v;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || o_busy || o_out_valid) && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("drain", ON'(sb.size()), '0);
    check("idle", ON'(o_busy), '0);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (!i_reset && o_out_valid && i_out_ready) begin
      if (sb.size() == 0) begin
        check("spurious", ON'(o_out_valid), '0);
      end else begin
        mon_e = sb.pop_front();
        check("col", o_out_col, mon_e.col);
        check("last", ON'(o_last), ON'(mon_e.last));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 9; i++) begin
      kset[i] = 0;
      kmod[i] = 0;
    end
    repeat (3) @(posedge clock);
    #1;
    i_reset = 1'b0;
    check("rst_valid", ON'(o_out_valid), '0);
    check("rst_busy", ON'(o_busy), '0);
    check("rst_last", ON'(o_last), '0);
    check("rst_col", o_out_col, '0);
    check("rst_rdy", ON'(o_col_ready), ON'(1));

    // identity kernel, sequential pixels
    set_kernel(1, 0);
    load_kernel(1'b1);
    fill_seq(1);
    push_frame();
    for (int c = 0; c < W; c++) begin
      send_col(c);
      if (c == 1)
        check("lat", ON'(o_out_valid), ON'(1));
    end
    drain();

    // all-ones kernel, all-ones pixels
    set_kernel(1, 1);
    load_kernel(1'b1);
    fill_const(1);
    push_frame();
    send_frame();
    drain();

    // negative center tap
    set_kernel(-1, 0);
    load_kernel(1'b1);
    fill_const(5);
    push_frame();
    send_frame();
    drain();

    // downstream stall for 5 cycles after the first output
    set_kernel(1, 0);
    load_kernel(1'b1);
    fill_seq(20);
    push_frame();
    i_out_ready = 1'b0;
    fork
      send_frame();
      begin
        int n;
        n = 0;
        while (!o_out_valid && n < 50) begin
          @(negedge clock);
          n++;
        end
        check("stall_vld", ON'(o_out_valid), ON'(1));
        repeat (5) begin
          @(negedge clock);
          check("stall_hold", o_out_col, sb[0].col);
          check("stall_rdy", ON'(o_col_ready), '0);
        end
        @(posedge clock);
        #1;
        i_out_ready = 1'b1;
      end
    join
    drain();

    // reset mid-frame; aborted frame must emit nothing
    i_out_ready = 1'b0;
    fill_seq(40);
    send_col(0);
    send_col(1);
    i_reset = 1'b1;
    @(posedge clock);
    #1;
    i_reset = 1'b0;
    for (int i = 0; i < 9; i++)
      kmod[i] = 0;
    check("mid_valid", ON'(o_out_valid), '0);
    check("mid_busy", ON'(o_busy), '0);
    check("mid_rdy", ON'(o_col_ready), ON'(1));
    i_out_ready = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("mid_quiet", ON'(o_out_valid), '0);
    end
    @(posedge clock);
    #1;
    set_kernel(1, 0);
    load_kernel(1'b1);
    fill_seq(1);
    push_frame();
    send_frame();
    drain();

    // kernel load during RUN is ignored for this and later frames
    fill_seq(60);
    push_frame();
    send_col(0);
    send_col(1);
    set_kernel(1, 1);
    load_kernel(1'b0);
    send_col(2);
    drain();
    fill_seq(3);
    push_frame();
    send_frame();
    drain();

    // random kernel and pixels under random backpressure
    for (int i = 0; i < 9; i++)
      kset[i] = int'($urandom_range(0, 255)) - 128;
    load_kernel(1'b1);
    fork
      begin
        repeat (4) begin
          for (int c = 0; c < W; c++)
            for (int r = 0; r < H; r++)
              fr[c][r] = int'($urandom_range(0, 255)) - 128;
          push_frame();
          send_frame();
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock);
          #1;
          i_out_ready = ($urandom_range(0, 3) != 0);
        end
        i_out_ready = 1'b1;
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_column_stream.md
CONV_COLUMN_STREAM -- requirements
Module: conv_column_stream

Interface
REQ-001 Parameter IMG_HEIGHT, default 8: pixels per column (rows), >=2.
REQ-002 Parameter IMG_WIDTH, default 16: columns per frame, >=2.
REQ-003 Parameter IMG_NB, default 8: signed pixel width.
REQ-004 Parameter KERNEL_NB, default 8: signed kernel coefficient width.
REQ-005 Parameter OUT_NB, default IMG_NB+KERNEL_NB+4: signed output pixel width.
REQ-006 clock  in  1  clock; all logic rising-edge.
REQ-007 i_reset  in  1  synchronous active-high reset.
REQ-008 i_kernel_load  in  1  latch i_kernel (honoured in IDLE only).
REQ-009 i_kernel  in  9*KERNEL_NB  3x3 kernel, row-major; k[0][0] at MSB slice, k[2][2] at LSB slice.
REQ-010 i_col_valid  in  1  input column valid.
REQ-011 o_col_ready  out  1  input column accepted when valid&&ready.
REQ-012 i_col  in  IMG_HEIGHT*IMG_NB  input column; row 0 at MSB slice.
REQ-013 o_out_valid  out  1  output column valid.
REQ-014 i_out_ready  in  1  downstream accepts output when valid&&ready.
REQ-015 o_out_col  out  IMG_HEIGHT*OUT_NB  output column; row 0 at MSB slice.
REQ-016 o_last  out  1  high with final output column of a frame.
REQ-017 o_busy  out  1  high whenever state != IDLE.

Function
REQ-018 Block SHALL compute a same-size 3x3 convolution, zero padding on all four borders: out[r][c] = sum over dr,dc in {-1,0,1} of k[dr+1][dc+1]*px[r+dr][c+dc], out-of-frame pixels = 0.
REQ-019 Window SHALL be three column registers L,M,R; each accepted column shifts L<=M, M<=R, R<=i_col.
REQ-020 States: IDLE, FILL, RUN, FLUSH; column counter 0..IMG_WIDTH-1.
REQ-021 IDLE: L,M cleared to 0; first accepted column -> FILL.
REQ-022 FILL -> RUN on second accepted column; that acceptance produces output column 0.
REQ-023 RUN: each acceptance produces next output column; acceptance of column IMG_WIDTH-1 -> FLUSH.
REQ-024 FLUSH: shift with R<=0 (no input accepted), produce output column IMG_WIDTH-1 with o_last=1, then -> IDLE.
REQ-025 Latency: o_out_valid SHALL rise exactly one cycle after the triggering acceptance (or FLUSH entry when output register free).
REQ-026 Output register SHALL hold o_out_col/o_last stable while o_out_valid && !i_out_ready.
REQ-027 o_col_ready SHALL be 1 in IDLE/FILL/RUN when (!o_out_valid || i_out_ready), else 0; always 0 in FLUSH.
REQ-028 Simultaneous output consume and new acceptance SHALL give back-to-back valid columns with no bubble.
REQ-029 Products full precision; sum sign-extended to OUT_NB, wrapping modulo 2^OUT_NB (no saturation).
REQ-030 i_kernel_load outside IDLE SHALL be ignored; kernel registers constant for the frame.
REQ-031 Total outputs per frame SHALL equal IMG_WIDTH exactly.

Reset
REQ-032 On i_reset: state IDLE, counter 0, L/M/R 0, kernel registers 0, o_out_valid 0, o_last 0, o_out_col 0, o_busy 0.
REQ-033 Reset mid-frame SHALL abort the frame; no partial output emitted after reset deasserts.
REQ-034 o_col_ready SHALL be 1 the first cycle after reset deasserts.

Configuration
REQ-035 Macro CONV_RELU_EN defined: each output pixel with negative sum SHALL be forced to 0 before registering.
REQ-036 CONV_RELU_EN undefined: signed wrapped sum output unmodified.

Verification (IMG_HEIGHT=4, IMG_WIDTH=3, IMG_NB=8, KERNEL_NB=8)
REQ-037 Identity kernel (k[1][1]=1, rest 0), columns {1,2,3,4},{5,6,7,8},{9,10,11,12} -> outputs equal inputs, o_last on third.
REQ-038 All-ones kernel, all pixels 1 -> col0 {4,6,6,4}, col1 {6,9,9,6}, col2 {4,6,6,4}.
REQ-039 Identity kernel with k[1][1]=-1, pixel 5 -> -5 without CONV_RELU_EN, 0 with it.
REQ-040 i_out_ready held 0 for 5 cycles after first output -> o_out_col stable, o_col_ready 0, no data lost.
REQ-041 i_reset pulsed after second column accepted -> o_out_valid 0, o_busy 0, next frame output matches REQ-037.
REQ-042 i_kernel_load with new kernel during RUN -> current frame uses old kernel.
